mem_port_arbiter: RTL and testbench

Arbitrates a single-ported, fixed-latency SRAM between two requesters: the IF stage's instruction fetch and the MEM stage's load/store. It sequences each access over a programmable number of wait cycles and returns read data with a one-cycle ready pulse. It drives the freeze signals that stall the IF stage PC and the downstream pipeline registers. It also discards an in-flight fetch when a branch flush arrives.

---
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/mem_port_arbiter.sv | 74 +++++++
 tb/tb_mem_port_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store, flush/freeze and SRAM signals of the memory port arbiter
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        flush;
    logic        freeze_if;
    logic        freeze_pipe;
    logic        sram_en;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    modport slave (
        input  if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, flush, sram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, freeze_if, freeze_pipe,
               sram_en, sram_we, sram_addr, sram_wdata
    );
    modport master (
        output if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, flush, sram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, freeze_if, freeze_pipe,
               sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a fixed-latency single-port SRAM between instruction fetch and load/store
module mem_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] IF_BUSY  = 2'd1;
    localparam logic [1:0] MEM_BUSY = 2'd2;
    localparam logic [1:0] DRAIN    = 2'd3;
    localparam logic [3:0] CNT_START = 4'(WAIT_CYCLES - 1);
    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        mem_req, last;
    assign mem_req = bus.mem_rd_en | bus.mem_wr_en;
    assign last    = cnt_q == 4'd0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 4'd1;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        if (state_q == IDLE) begin
            cnt_d = cnt_q;
            if (mem_req) begin
                state_d = MEM_BUSY;
                cnt_d   = CNT_START;
                addr_d  = bus.mem_addr;
                wdata_d = bus.mem_wdata;
                we_d    = bus.mem_wr_en;
            end else if (bus.if_req && !bus.flush) begin
                state_d = IF_BUSY;
                cnt_d   = CNT_START;
                addr_d  = bus.if_addr;
                we_d    = 1'b0;
            end
        end else if (last) begin
            state_d = IDLE;
            cnt_d   = cnt_q;
        end else if (state_q == IF_BUSY && bus.flush) begin
            state_d = DRAIN;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end
    // A flush in the final fetch cycle suppresses the pulse; the drained result is never returned
    assign bus.if_ready    = state_q == IF_BUSY && last && !bus.flush;
    assign bus.if_rdata    = bus.if_ready ? bus.sram_rdata : '0;
    assign bus.mem_ready   = state_q == MEM_BUSY && last;
    assign bus.mem_rdata   = (bus.mem_ready && !we_q) ? bus.sram_rdata : '0;
    assign bus.freeze_if   = rst_n && bus.if_req && !bus.if_ready;
    assign bus.freeze_pipe = rst_n && mem_req && !bus.mem_ready;
    assign bus.sram_en     = state_q != IDLE;
    assign bus.sram_we     = state_q == MEM_BUSY && we_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_wdata  = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks against a cycle-timeline model of the arbiter
module tb_mem_port_arbiter;
    localparam int W = 3;
    localparam logic [31:0] K = 32'hE3A00014;
    logic clk, rst_n;
    int checks = 0, failures = 0;
    int kind, fl, k;
    bit fi, rd, wr;
    mem_port_arbiter_if a();
    mem_port_arbiter_if b();
    mem_port_arbiter #(.WAIT_CYCLES(W)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    mem_port_arbiter #(.WAIT_CYCLES(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));
    // SRAM content is a fixed function of the address, so read data also proves the address used
    assign a.sram_rdata = a.sram_addr ^ K;
    assign b.sram_rdata = b.sram_addr ^ K;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected timeline: each grant g occupies the SRAM for cycles g+1..g+W, ready at g+W
    task automatic run_a(input bit do_if, input bit do_rd, input bit do_wr, input int flc,
                         input logic [31:0] ia, input logic [31:0] ia2,
                         input logic [31:0] ma, input logic [31:0] wd);
        int g_st[3];
        logic [31:0] g_ad[3];
        bit g_we[3];
        int n, f_rdy, d_rdy, g, last;
        logic [31:0] f_ad, ad;
        bit en, we;
        n = 0; f_rdy = -1; d_rdy = -1; f_ad = '0;
        if (do_rd || do_wr) begin
            g_st[0] = 0; g_ad[0] = ma; g_we[0] = do_wr; n = 1; d_rdy = W;
        end
        if (do_if) begin
            g = (n != 0) ? W + 1 : 0;
            if (flc == g) g++;
            f_ad = (flc >= 0 && flc <= g) ? ia2 : ia;
            g_st[n] = g; g_ad[n] = f_ad; g_we[n] = 1'b0; n++;
            f_rdy = g + W;
            if (flc > g && flc <= g + W) begin
                g_st[n] = g + W + 1; g_ad[n] = ia2; g_we[n] = 1'b0; n++;
                f_ad = ia2; f_rdy = g + 2 * W + 1;
            end
        end
        last = f_rdy > d_rdy ? f_rdy : d_rdy;
        for (int c = 0; c <= last + 1; c++) begin
            a.if_req    = do_if && c <= f_rdy;
            a.if_addr   = (flc >= 0 && c >= flc) ? ia2 : ia;
            a.flush     = c == flc;
            a.mem_rd_en = do_rd && c <= d_rdy;
            a.mem_wr_en = do_wr && c <= d_rdy;
            a.mem_addr  = ma;
            a.mem_wdata = wd;
            en = 1'b0; we = 1'b0; ad = '0;
            for (int i = 0; i < n; i++)
                if (c > g_st[i] && c <= g_st[i] + W) begin
                    en = 1'b1; we = g_we[i]; ad = g_ad[i];
                end
            @(negedge clk);
            chk("sram_en", 32'(a.sram_en), 32'(en));
            chk("sram_we", 32'(a.sram_we), 32'(we));
            if (en) chk("sram_addr", a.sram_addr, ad);
            if (we) chk("sram_wdata", a.sram_wdata, wd);
            chk("if_ready", 32'(a.if_ready), 32'(c == f_rdy));
            chk("if_rdata", a.if_rdata, (c == f_rdy) ? (f_ad ^ K) : 32'h0);
            chk("mem_ready", 32'(a.mem_ready), 32'(c == d_rdy));
            chk("mem_rdata", a.mem_rdata, (c == d_rdy && do_rd) ? (ma ^ K) : 32'h0);
            chk("freeze_if", 32'(a.freeze_if), 32'(do_if && c < f_rdy));
            chk("freeze_pipe", 32'(a.freeze_pipe), 32'((do_rd || do_wr) && c < d_rdy));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        clk = 0; rst_n = 0;
        a.if_req = 0; a.if_addr = 0; a.mem_rd_en = 0; a.mem_wr_en = 0;
        a.mem_addr = 0; a.mem_wdata = 0; a.flush = 0;
        b.if_req = 0; b.if_addr = 0; b.mem_rd_en = 0; b.mem_wr_en = 0;
        b.mem_addr = 0; b.mem_wdata = 0; b.flush = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sram_en", 32'(a.sram_en), 32'h0);
        chk("rst_sram_addr", a.sram_addr, 32'h0);
        chk("rst_if_ready", 32'(a.if_ready), 32'h0);
        chk("rst_mem_ready", 32'(a.mem_ready), 32'h0);
        rst_n = 1;
        @(posedge clk); #1;
        // fetch, fetch+load collision, store, fetch with mid-access flush
        run_a(1, 0, 0, -1, 32'h0, 32'h0, 32'h0, 32'h0);
        run_a(1, 1, 0, -1, 32'h100, 32'h100, 32'h400, 32'h0);
        run_a(0, 0, 1, -1, 32'h0, 32'h0, 32'h400, 32'h2000);
        run_a(1, 0, 0, 2, 32'h0, 32'h90, 32'h0, 32'h0);
        run_a(1, 0, 0, 0, 32'h40, 32'h80, 32'h0, 32'h0);
        run_a(1, 0, 0, W, 32'h44, 32'h88, 32'h0, 32'h0);
        // reset asserted mid-load
        a.mem_rd_en = 1; a.mem_addr = 32'h800; a.if_req = 1; a.if_addr = 32'hC;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("pre_rst_sram_en", 32'(a.sram_en), 32'h1);
        rst_n = 0; #1;
        chk("midrst_sram_en", 32'(a.sram_en), 32'h0);
        chk("midrst_mem_ready", 32'(a.mem_ready), 32'h0);
        chk("midrst_freeze_pipe", 32'(a.freeze_pipe), 32'h0);
        chk("midrst_freeze_if", 32'(a.freeze_if), 32'h0);
        chk("midrst_sram_addr", a.sram_addr, 32'h0);
        a.mem_rd_en = 0; a.if_req = 0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        run_a(0, 1, 0, -1, 32'h0, 32'h0, 32'h804, 32'h0);
        // WAIT_CYCLES=1 instance: five back-to-back fetches
        k = 0; b.if_addr = 0; b.if_req = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("w1_sram_en", 32'(b.sram_en), 32'(c % 2));
            chk("w1_if_ready", 32'(b.if_ready), 32'(c % 2));
            chk("w1_if_rdata", b.if_rdata, (c % 2 == 1) ? (32'(4 * k) ^ K) : 32'h0);
            chk("w1_freeze_if", 32'(b.freeze_if), 32'(c % 2 == 0));
            @(posedge clk); #1;
            if (c % 2 == 1) begin k++; b.if_addr = 32'(4 * k); end
            if (c == 9) b.if_req = 0;
        end
        @(negedge clk);
        chk("w1_idle_en", 32'(b.sram_en), 32'h0);
        @(posedge clk); #1;
        // randomized mix of fetches, loads, stores, collisions and flushes
        for (int t = 0; t < 24; t++) begin
            kind = int'($urandom_range(0, 3));
            fi = kind == 0 || kind == 3;
            rd = kind == 1 || (kind == 3 && $urandom_range(0, 1) == 1);
            wr = kind == 2 || (kind == 3 && !rd);
            fl = (!fi || $urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, (rd || wr) ? 2 * W + 1 : W));
            run_a(fi, rd, wr, fl, $urandom, $urandom, $urandom, $urandom);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
